// File: rtl/mips_pkg.sv
// mips_pkg: opcode encodings, the opcode enum, default datapath widths and
// per-opcode register-usage helpers shared by the decode/issue stage and the
// ALU/memory stages downstream.
package mips_pkg;

    // Default widths; stages take these as parameter defaults.
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_MEM_AW = 11;

    localparam logic [2:0] OPC_LI  = 3'b000;
    localparam logic [2:0] OPC_ADI = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_CMP = 3'b011;
    localparam logic [2:0] OPC_LW  = 3'b100;
    localparam logic [2:0] OPC_SW  = 3'b101;
    localparam logic [2:0] OPC_J   = 3'b110;
    localparam logic [2:0] OPC_BEQ = 3'b111;

    typedef enum logic [2:0] {
        OP_LI  = OPC_LI,
        OP_ADI = OPC_ADI,
        OP_ADD = OPC_ADD,
        OP_CMP = OPC_CMP,
        OP_LW  = OPC_LW,
        OP_SW  = OPC_SW,
        OP_J   = OPC_J,
        OP_BEQ = OPC_BEQ
    } opcode_t;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_BR_WAIT = 1'b1
    } issue_state_t;

    // Instructions whose rd field names a destination register.
    function automatic logic is_writer(input opcode_t op);
        return (op == OP_LI) || (op == OP_ADI) || (op == OP_ADD) || (op == OP_LW);
    endfunction

    // rd is a source for compares, branches and the store-data register.
    function automatic logic reads_rd(input opcode_t op);
        return (op == OP_CMP) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

    function automatic logic reads_rs(input opcode_t op);
        return (op == OP_ADD) || (op == OP_ADI) || (op == OP_CMP) || (op == OP_BEQ);
    endfunction

    function automatic logic reads_rt(input opcode_t op);
        return (op == OP_ADD);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: one pending bit per architectural register.
//   clock, reset          rising-edge clock, async active-high reset
//   set_en/set_addr       mark a register as having a write in flight
//   clr_en/clr_addr       writeback retiring that register
//   look_a/b/c            three lookup addresses
//   busy_a/b/c            pending, with a same-cycle writeback seen as clear
module reg_scoreboard #(
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic [REG_AW-1:0] look_a,
    input  logic [REG_AW-1:0] look_b,
    input  logic [REG_AW-1:0] look_c,
    output logic              busy_a,
    output logic              busy_b,
    output logic              busy_c
);
    import mips_pkg::*;

    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0] pending;

    // NOTE: this bit array is reset, unlike a plain data RAM, because a reset
    // must forget every in-flight write or issue would deadlock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            // NOTE: non-blocking assignments; the later set overrides the
            // earlier clear when both target the same register this cycle.
            if (clr_en) pending[clr_addr] <= 1'b0;
            if (set_en) pending[set_addr] <= 1'b1;
        end
    end

    // Writeback bypass: a register retiring this cycle no longer blocks.
    assign busy_a = pending[look_a] && !(clr_en && (clr_addr == look_a));
    assign busy_b = pending[look_b] && !(clr_en && (clr_addr == look_b));
    assign busy_c = pending[look_c] && !(clr_en && (clr_addr == look_c));

endmodule

// File: rtl/decode_issue.sv
// decode_issue: decodes the 3-bit-opcode ISA into a registered issue bundle,
// with valid/ready on both sides, RAW/WAW stalls from a register scoreboard
// and a branch-wait state that blocks issue after J/BEQ until br_done.
//   clock, reset                 rising-edge clock, async active-high reset
//   in_valid/in_ready            fetch handshake (in_ready combinational)
//   instruction_in               instruction word
//   out_valid/out_ready          downstream handshake for the bundle
//   alu_op, alu_en, mem_rd, mem_wr, rd/rs/rt_addr, mem_addr, imm   bundle
//   wb_valid/wb_addr             writeback retiring a register write
//   br_done                      pulse: outstanding branch resolved
module decode_issue
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int MEM_AW = DEF_MEM_AW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instruction_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        alu_op,
    output logic              alu_en,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [REG_AW-1:0] rd_addr,
    output logic [REG_AW-1:0] rs_addr,
    output logic [REG_AW-1:0] rt_addr,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] imm,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic              br_done
);

    localparam int IMM_W = DATA_W - 3 - REG_AW;

    // ---------------- field extraction ----------------
    opcode_t           op;
    logic [REG_AW-1:0] f_rd, f_rs, f_rt;

    assign op   = opcode_t'(instruction_in[DATA_W-1 -: 3]);
    assign f_rd = instruction_in[DATA_W-4 -: REG_AW];
    assign f_rs = instruction_in[DATA_W-4-REG_AW -: REG_AW];
    assign f_rt = instruction_in[DATA_W-4-2*REG_AW -: REG_AW];

    logic use_rd, use_rs, use_rt;
    assign use_rd = is_writer(op) || reads_rd(op);
    assign use_rs = reads_rs(op);
    assign use_rt = reads_rt(op);

    // ---------------- decode ----------------
    logic              d_alu_en, d_mem_rd, d_mem_wr;
    logic [MEM_AW-1:0] d_mem_addr;
    logic [DATA_W-1:0] d_imm;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        d_alu_en   = 1'b0;
        d_mem_rd   = 1'b0;
        d_mem_wr   = 1'b0;
        d_mem_addr = '0;
        d_imm      = '0;
        case (op)
            OP_LI:  begin
                d_alu_en = 1'b1;
                d_imm    = {{(DATA_W-IMM_W){1'b0}}, instruction_in[IMM_W-1:0]};
            end
            OP_ADI: begin
                d_alu_en = 1'b1;
                d_imm    = {{(DATA_W-8){1'b0}}, instruction_in[7:0]};
            end
            OP_ADD: d_alu_en = 1'b1;
            OP_LW:  begin
                d_mem_rd   = 1'b1;
                d_mem_addr = instruction_in[MEM_AW-1:0];
            end
            OP_SW:  begin
                d_mem_wr   = 1'b1;
                d_mem_addr = instruction_in[MEM_AW-1:0];
            end
            OP_J, OP_BEQ: d_imm = {{(DATA_W-8){1'b0}}, instruction_in[7:0]};
            default: ;
        endcase
    end

    // ---------------- scoreboard / hazard ----------------
    logic busy_rd, busy_rs, busy_rt, hazard, accept;

    reg_scoreboard #(.REG_AW(REG_AW)) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .set_en   (accept && is_writer(op)),
        .set_addr (f_rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .look_a   (f_rd),
        .look_b   (f_rs),
        .look_c   (f_rt),
        .busy_a   (busy_rd),
        .busy_b   (busy_rs),
        .busy_c   (busy_rt)
    );

    // A writer whose rd is pending is a WAW hazard; a reader of rd is RAW.
    assign hazard = (use_rd && busy_rd) || (use_rs && busy_rs) || (use_rt && busy_rt);

    // ---------------- branch-wait FSM ----------------
    issue_state_t state, state_nxt;
    logic         issue_open;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:     if (accept && ((op == OP_J) || (op == OP_BEQ))) state_nxt = ST_BR_WAIT;
            ST_BR_WAIT: if (br_done) state_nxt = ST_RUN;
            default:    state_nxt = ST_RUN;
        endcase
    end

    // Branch wait blocks new accepts only; a held bundle still drains.
    always_comb begin
        issue_open = (state == ST_RUN);
    end

    assign in_ready = issue_open && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // ---------------- output bundle register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            alu_op    <= '0;
            alu_en    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            rd_addr   <= '0;
            rs_addr   <= '0;
            rt_addr   <= '0;
            mem_addr  <= '0;
            imm       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_op    <= op;
            alu_en    <= d_alu_en;
            mem_rd    <= d_mem_rd;
            mem_wr    <= d_mem_wr;
            rd_addr   <= use_rd ? f_rd : '0;
            rs_addr   <= use_rs ? f_rs : '0;
            rt_addr   <= use_rt ? f_rt : '0;
            mem_addr  <= d_mem_addr;
            imm       <= d_imm;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed stimulus for decode_issue. Accepted instructions
// push a hand-computed bundle into a queue; an independent monitor pops and
// compares whenever the DUT completes an output handshake.
module tb_decode_issue;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] instruction_in;
    logic        out_valid, out_ready;
    logic [2:0]  alu_op;
    logic        alu_en, mem_rd, mem_wr;
    logic [4:0]  rd_addr, rs_addr, rt_addr;
    logic [10:0] mem_addr;
    logic [31:0] imm;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        br_done;

    decode_issue dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instruction_in (instruction_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_op         (alu_op),
        .alu_en         (alu_en),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .rd_addr        (rd_addr),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .mem_addr       (mem_addr),
        .imm            (imm),
        .wb_valid       (wb_valid),
        .wb_addr        (wb_addr),
        .br_done        (br_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  op;
        logic        en;
        logic        mrd;
        logic        mwr;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [10:0] ma;
        logic [31:0] im;
    } bundle_t;

    bundle_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [2:0] op, input logic en, input logic mrd,
                                   input logic mwr, input logic [4:0] rd, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [10:0] ma,
                                   input logic [31:0] im);
        return '{op: op, en: en, mrd: mrd, mwr: mwr, rd: rd, rs: rs, rt: rt, ma: ma, im: im};
    endfunction

    function automatic logic [31:0] ins(input logic [2:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [13:0] low);
        return {op, rd, rs, rt, low};
    endfunction

    function automatic logic [31:0] ins_li(input logic [4:0] rd, input logic [23:0] v);
        return {3'b000, rd, v};
    endfunction

    // Monitor: samples after the stimulus has settled its negedge updates.
    always begin
        @(negedge clock);
        #2;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected bundle", 64'd1, 64'd0);
            end else begin
                check("bundle",
                      {alu_op, alu_en, mem_rd, mem_wr, rd_addr, rs_addr, rt_addr, mem_addr, imm},
                      exp_q.pop_front());
            end
        end
    end

    // Called just after a negedge with inputs set: checks in_ready, records the
    // expected bundle if this cycle accepts, and returns at the next negedge.
    task automatic step(input string name, input logic exp_ready, input bundle_t e);
        #1;
        check(name, {63'd0, in_ready}, {63'd0, exp_ready});
        if (in_valid && in_ready) begin
            @(posedge clock);
            exp_q.push_back(e);
        end
        @(negedge clock);
    endtask

    bundle_t b_none;

    initial begin
        b_none = '0;
        // NOTE: inputs are driven with blocking assignments from this process.
        reset          = 1'b1;
        in_valid       = 1'b0;
        instruction_in = '0;
        out_ready      = 1'b1;
        wb_valid       = 1'b0;
        wb_addr        = '0;
        br_done        = 1'b0;

        repeat (2) @(negedge clock);
        #1;
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset bundle",
              {alu_op, alu_en, mem_rd, mem_wr, rd_addr, rs_addr, rt_addr, mem_addr, imm}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        step("ready after reset", 1'b1, b_none);

        // LI r3 then dependent ADD r6,r3,r1 issuing on the writeback bypass.
        in_valid = 1'b1;
        instruction_in = ins_li(5'd3, 24'h00ABCD);
        step("li r3 accept", 1'b1, mk(3'b000, 1, 0, 0, 5'd3, 0, 0, 0, 32'h0000ABCD));
        instruction_in = ins(3'b010, 5'd6, 5'd3, 5'd1, 14'd0);
        #1;
        check("li r3 out_valid", {63'd0, out_valid}, 64'd1);
        check("li r3 alu_en", {63'd0, alu_en}, 64'd1);
        @(negedge clock);
        step("add r6 stall", 1'b0, b_none);
        wb_valid = 1'b1; wb_addr = 5'd3;
        step("add r6 bypass", 1'b1, mk(3'b010, 1, 0, 0, 5'd6, 5'd3, 5'd1, 0, 0));
        wb_valid = 1'b0;

        // LW r4 then ADD r5,r4,r1 held until writeback of r4.
        instruction_in = ins(3'b100, 5'd4, 5'd0, 5'd0, 14'h07FF);
        step("lw r4 accept", 1'b1, mk(3'b100, 0, 1, 0, 5'd4, 0, 0, 11'h7FF, 0));
        instruction_in = ins(3'b010, 5'd5, 5'd4, 5'd1, 14'd0);
        for (int i = 0; i < 3; i++) step("add r5 stall", 1'b0, b_none);
        wb_valid = 1'b1; wb_addr = 5'd4;
        step("add r5 bypass", 1'b1, mk(3'b010, 1, 0, 0, 5'd5, 5'd4, 5'd1, 0, 0));
        wb_valid = 1'b0;

        // WAW on r2, and set-over-clear in the same cycle.
        instruction_in = ins_li(5'd2, 24'h000001);
        step("li r2 first", 1'b1, mk(3'b000, 1, 0, 0, 5'd2, 0, 0, 0, 32'h1));
        instruction_in = ins_li(5'd2, 24'h000002);
        for (int i = 0; i < 2; i++) step("li r2 waw stall", 1'b0, b_none);
        wb_valid = 1'b1; wb_addr = 5'd2;
        step("li r2 second", 1'b1, mk(3'b000, 1, 0, 0, 5'd2, 0, 0, 0, 32'h2));
        wb_valid = 1'b0;
        // ADI r7,r2,5 with junk in the rt field: r2 must still be pending.
        instruction_in = ins(3'b001, 5'd7, 5'd2, 5'd9, 14'h0005);
        step("adi r2 still pending", 1'b0, b_none);
        wb_valid = 1'b1; wb_addr = 5'd2;
        step("adi accept", 1'b1, mk(3'b001, 1, 0, 0, 5'd7, 5'd2, 0, 0, 32'h5));
        wb_valid = 1'b0;

        // BEQ r1,r2,0x10 then J blocked until after br_done.
        instruction_in = ins(3'b111, 5'd1, 5'd2, 5'd0, 14'h0010);
        step("beq accept", 1'b1, mk(3'b111, 0, 0, 0, 5'd1, 5'd2, 0, 0, 32'h10));
        instruction_in = ins(3'b110, 5'd3, 5'd0, 5'd0, 14'h0020);
        for (int i = 0; i < 3; i++) step("j branch wait", 1'b0, b_none);
        br_done = 1'b1;
        step("j during br_done", 1'b0, b_none);
        br_done = 1'b0;
        step("j after br_done", 1'b1, mk(3'b110, 0, 0, 0, 0, 0, 0, 0, 32'h20));
        in_valid = 1'b0;
        br_done = 1'b1;
        step("idle in j wait", 1'b0, b_none);
        br_done = 1'b0;

        // SW r7,0x123 held under back-pressure (r7 cleared by bypass).
        in_valid = 1'b1;
        instruction_in = ins(3'b101, 5'd7, 5'd0, 5'd0, 14'h0123);
        wb_valid = 1'b1; wb_addr = 5'd7;
        out_ready = 1'b0;
        step("sw accept", 1'b1, mk(3'b101, 0, 0, 1, 5'd7, 0, 0, 11'h123, 0));
        wb_valid = 1'b0;
        instruction_in = ins_li(5'd8, 24'h000055);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("sw held valid", {63'd0, out_valid}, 64'd1);
            check("sw held mem_wr", {63'd0, mem_wr}, 64'd1);
            check("sw held mem_addr", {53'd0, mem_addr}, 64'h123);
            check("sw held rd", {59'd0, rd_addr}, 64'd7);
            check("sw backpressure ready", {63'd0, in_ready}, 64'd0);
            @(negedge clock);
        end
        out_ready = 1'b1;
        step("li r8 on drain", 1'b1, mk(3'b000, 1, 0, 0, 5'd8, 0, 0, 0, 32'h55));

        // Reset inside BR_WAIT with r5, r6, r8 still pending.
        instruction_in = ins(3'b111, 5'd0, 5'd1, 5'd0, 14'h0000);
        step("beq2 accept", 1'b1, mk(3'b111, 0, 0, 0, 0, 5'd1, 0, 0, 0));
        in_valid = 1'b0;
        step("beq2 wait", 1'b0, b_none);
        reset = 1'b1;
        #1;
        check("mid reset out_valid", {63'd0, out_valid}, 64'd0);
        check("mid reset bundle",
              {alu_op, alu_en, mem_rd, mem_wr, rd_addr, rs_addr, rt_addr, mem_addr, imm}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        in_valid = 1'b1;
        instruction_in = ins_li(5'd5, 24'h000001);
        step("li r5 after reset", 1'b1, mk(3'b000, 1, 0, 0, 5'd5, 0, 0, 0, 32'h1));
        instruction_in = ins(3'b010, 5'd9, 5'd6, 5'd8, 14'd0);
        step("add forgotten pending", 1'b1, mk(3'b010, 1, 0, 0, 5'd9, 5'd6, 5'd8, 0, 0));
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        #3;
        check("queue drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
# decode_issue

Parametrised instruction decode/issue stage for the MIPS pipeline, sitting between fetch and the ALU/memory stage. Decodes the 3-bit opcode ISA into ALU/memory control and register/immediate fields, registered once. Adds valid/ready handshakes on both sides, a register scoreboard that stalls RAW/WAW hazards until writeback, and a branch-wait state that blocks issue after J/BEQ until the branch resolves.

## Interface
- DATA_W, 32, instruction and immediate width
- REG_AW, 5, register address width; scoreboard has 2**REG_AW entries
- MEM_AW, 11, data-memory address width; MEM_AW <= DATA_W-3-REG_AW
- IMM_W, DATA_W-3-REG_AW (derived, not overridable), LI immediate width
---
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents instruction_in
- in_ready  out  1  stage accepts this cycle (combinational)
- instruction_in  in  DATA_W  instruction word
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- alu_op  out  3  opcode of issued instruction
- alu_en  out  1  LI/ADI/ADD
- mem_rd  out  1  LW
- mem_wr  out  1  SW
- rd_addr / rs_addr / rt_addr  out  REG_AW each  register fields
- mem_addr  out  MEM_AW  LW/SW address
- imm  out  DATA_W  zero-extended immediate
- wb_valid  in  1  writeback retiring a register write
- wb_addr  in  REG_AW  register being written back
- br_done  in  1  one-cycle pulse: outstanding J/BEQ resolved

## Operation
- Opcodes: LI=000, ADI=001, ADD=010, CMP=011, LW=100, SW=101, J=110, BEQ=111.
- Fields: op=instr[DATA_W-1 -: 3], rd=[DATA_W-4 -: REG_AW], rs=next REG_AW bits down, rt=next REG_AW below rs; mem_addr=[MEM_AW-1:0].
- imm: LI -> [IMM_W-1:0]; ADI, J, BEQ -> [7:0]; others 0. Always zero-extended to DATA_W.
- Unused fields of a bundle are driven 0 (not held from prior instruction).
- Sources read: ADD rs,rt; ADI rs; CMP rd,rs; BEQ rd,rs; SW rd (store data). LI, LW, J read none.
- Writers (dest rd): LI, ADI, ADD, LW. CMP, SW, J, BEQ write none.
- hazard = any read source pending, or writer whose rd is pending. A pending bit cleared by wb_valid/wb_addr in the same cycle counts as not pending (writeback bypass).
- in_ready = (state==RUN) && !hazard && (!out_valid || out_ready). Accept = in_valid && in_ready.
- On accept: output bundle loaded, out_valid=1; writer sets pending[rd]. On out_ready && !accept: out_valid=0. Otherwise bundle held stable.
- Scoreboard: wb_valid clears pending[wb_addr]; set on accept wins over a same-cycle clear of the same address.
- FSM RUN -> BR_WAIT on accepting J or BEQ. BR_WAIT -> RUN on br_done. br_done in RUN ignored. BR_WAIT blocks accept only; held bundle still drains.

## Timing
- Reset (async): out_valid, all bundle outputs, scoreboard = 0; state RUN. in_ready may assert first cycle after reset deasserts.
- Latency 1: accept at edge N -> bundle visible after edge N, out_valid high until handshaken.
- Full throughput: back-to-back independent instructions issue every cycle with out_ready=1.
- Dependent instruction: issues the cycle wb_valid for its source is high (bypass), not later.
- Branch: earliest next accept is the cycle after br_done is sampled.
- Reset mid-stall or in BR_WAIT: everything cleared, pending writes forgotten.

## Structure
- mips_pkg: opcode localparams, opcode typedef, default width constants shared with ALU/memory stages.
- Sub-module reg_scoreboard (set/clear/lookup of 2**REG_AW pending bits, 3 read ports); rest is decode + handshake + FSM in decode_issue.

## Test plan
- Reset, then LI r3,0x00ABCD with out_ready=1 -> next cycle out_valid=1, alu_en=1, rd_addr=3, imm=0x00ABCD; pending[3]=1.
- LW r4,0x7FF then ADD r5,r4,r1 -> ADD held, in_ready=0 until wb_valid/wb_addr=4; ADD issues that same cycle.
- LI r2 then LI r2 (WAW) -> second stalls until wb of r2; same-cycle wb_addr=2 with new LI r2 leaves pending[2]=1.
- BEQ r1,r2,imm=0x10 -> bundle imm=0x10, mem_wr=0; following J not accepted until br_done pulse, accepted next cycle.
- out_ready=0 for 3 cycles with bundle SW r7,0x123 -> mem_wr, mem_addr=0x123, rd_addr=7 stable; in_ready=0; drains on out_ready.
- Assert reset during BR_WAIT with pending bits set -> out_valid=0, scoreboard cleared, LI accepted right after release.
